// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, control-word layout, ALU encodings and the decoder.
// Used by the ID stage, control and execute_stage so every stage agrees on ctrl bit positions.
package decode_pkg;

    localparam int CTRL_W = 14;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ctrl = {1'b0, reg_write, mem_read, mem_write, alu_src[1:0], mem_to_reg[1:0], branch, jump, alu_op[3:0]}
    localparam int CTRL_REG_WRITE  = 12;
    localparam int CTRL_MEM_READ   = 11;
    localparam int CTRL_MEM_WRITE  = 10;
    localparam int CTRL_ALU_SRC    = 8;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_ALU_OP     = 0;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // alu_src: operand B from rs2, or imm; SRC_PC means A=pc, B=imm
    localparam logic [1:0] SRC_RS2 = 2'd0;
    localparam logic [1:0] SRC_IMM = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              use_rs1;
        logic              use_rs2;
        logic [31:0]       imm;
    } dec_t;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic rw, input logic mr, input logic mw,
        input logic [1:0] src, input logic [1:0] m2r,
        input logic br, input logic jp, input logic [3:0] op);
        return {1'b0, rw, mr, mw, src, m2r, br, jp, op};
    endfunction

    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] alu_branch(input logic [2:0] f3);
        case (f3[2:1])
            2'b10:   return ALU_SLT;
            2'b11:   return ALU_SLTU;
            default: return ALU_SUB;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [2:0] f3;
        f3        = ins[14:12];
        d.ctrl    = '0;
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b0;
        d.imm     = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            OP_REG: begin
                d.ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, SRC_RS2, WB_ALU, 1'b0, 1'b0, alu_arith(f3, ins[30]));
                d.use_rs2 = 1'b1;
            end
            // only SRAI uses funct7; ADDI with a negative imm must not become SUB
            OP_IMM:  d.ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, SRC_IMM, WB_ALU, 1'b0, 1'b0,
                                        alu_arith(f3, (f3 == 3'd5) & ins[30]));
            OP_LOAD: d.ctrl = pack_ctrl(1'b1, 1'b1, 1'b0, SRC_IMM, WB_MEM, 1'b0, 1'b0, ALU_ADD);
            OP_STORE: begin
                d.imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                d.ctrl    = pack_ctrl(1'b0, 1'b0, 1'b1, SRC_IMM, WB_ALU, 1'b0, 1'b0, ALU_ADD);
                d.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                d.imm     = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                d.ctrl    = pack_ctrl(1'b0, 1'b0, 1'b0, SRC_RS2, WB_ALU, 1'b1, 1'b0, alu_branch(f3));
                d.use_rs2 = 1'b1;
            end
            OP_JAL: begin
                d.imm     = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                d.ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, SRC_PC, WB_PC4, 1'b0, 1'b1, ALU_ADD);
                d.use_rs1 = 1'b0;
            end
            OP_JALR: d.ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, SRC_IMM, WB_PC4, 1'b0, 1'b1, ALU_ADD);
            OP_LUI: begin
                d.imm     = {ins[31:12], 12'h000};
                d.ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, SRC_IMM, WB_ALU, 1'b0, 1'b0, ALU_PASSB);
                d.use_rs1 = 1'b0;
            end
            OP_AUIPC: begin
                d.imm     = {ins[31:12], 12'h000};
                d.ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, SRC_PC, WB_ALU, 1'b0, 1'b0, ALU_ADD);
                d.use_rs1 = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Per-register countdown of loads that have left EX but whose data is not yet forwardable.
// busy also covers a load still sitting in the ID/EX register.
module load_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic [AW-1:0] arm_rd,
    input  logic          ex_load,
    input  logic [AW-1:0] ex_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0][2:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (arm && arm_rd == AW'(r))
                    cnt[r] <= 3'(LOAD_LAT);
                else if (cnt[r] != 3'd0)
                    cnt[r] <= cnt[r] - 3'd1;
            end
        end
    end

    assign busy1 = (rs1 != '0) && ((ex_load && ex_rd == rs1) || (cnt[rs1] != 3'd0));
    assign busy2 = (rs2 != '0) && ((ex_load && ex_rd == rs2) || (cnt[rs2] != 3'd0));

endmodule

// File: rtl/decode_stage_sb.sv
// ID stage: decode, 2R1W regfile, load-use hazard detection and the ID/EX pipeline register,
// with valid/ready handshakes toward IF/ID and EX.
module decode_stage_sb
    import decode_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  NREG      = 32,
    parameter int  LOAD_LAT  = 0,
    parameter int  WB_BYPASS = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rdata1,
    output logic [XLEN-1:0]   out_rdata2,
    output logic [XLEN-1:0]   out_imm,
    output logic [AW-1:0]     out_rs1,
    output logic [AW-1:0]     out_rs2,
    output logic [AW-1:0]     out_rd,
    output logic [31:0]       out_instr,
    output logic              hz_stall
);

    dec_t            dec;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            busy1, busy2, adv, arm;
    logic [XLEN-1:0] rdata1, rdata2, imm_x;
    logic [XLEN-1:0] regs [NREG];

    assign dec   = decode(in_instr);
    assign rs1   = in_instr[15 +: AW];
    assign rs2   = in_instr[20 +: AW];
    assign rd    = in_instr[7 +: AW];
    assign imm_x = XLEN'($signed(dec.imm));

    assign hz_stall = in_valid & ((dec.use_rs1 & busy1) | (dec.use_rs2 & busy2));
    assign adv      = !out_valid | ex_ready;
    // a flushed ID word is dropped, so it counts as consumed
    assign in_ready = flush | (adv & !hz_stall);
    assign arm      = out_valid & ex_ready & out_ctrl[CTRL_MEM_READ] & (out_rd != '0) & !flush;

    load_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .arm_rd  (out_rd),
        .ex_load (out_valid & out_ctrl[CTRL_MEM_READ]),
        .ex_rd   (out_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy1   (busy1),
        .busy2   (busy2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rdata1 = regs[rs1];
        if (WB_BYPASS != 0 && wb_we && wb_rd == rs1) rdata1 = wb_data;
        if (rs1 == '0) rdata1 = '0;
        rdata2 = regs[rs2];
        if (WB_BYPASS != 0 && wb_we && wb_rd == rs2) rdata2 = wb_data;
        if (rs2 == '0) rdata2 = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_pc     <= '0;
            out_rdata1 <= '0;
            out_rdata2 <= '0;
            out_imm    <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_instr  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv && hz_stall) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid  <= in_valid;
            out_ctrl   <= dec.ctrl;
            out_pc     <= in_pc;
            out_rdata1 <= rdata1;
            out_rdata2 <= rdata2;
            out_imm    <= imm_x;
            out_rs1    <= rs1;
            out_rs2    <= rs2;
            out_rd     <= rd;
            out_instr  <= in_instr;
        end
    end

endmodule

// File: tb/tb_decode_stage_sb.sv
// Directed bench: decode table on LOAD_LAT=0, plus hazard, backpressure, flush, reset and bypass sequences
// across three parameterisations driven from shared inputs.
module tb_decode_stage_sb;

    localparam int ND = 3;  // 0: LAT0/bypass, 1: LAT2/bypass, 2: LAT0/no bypass

    localparam logic [31:0] I_LW    = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] I_ADD   = 32'h00228333;  // add  x6,x5,x2
    localparam logic [31:0] I_ADDI  = 32'h002083B3;  // add  x7,x1,x2
    localparam logic [31:0] I_NEG   = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] I_LUI   = 32'h123452B7;  // lui  x5,0x12345
    localparam logic [31:0] I_JAL   = 32'h008002EF;  // jal  x5,8
    localparam logic [31:0] I_ADD33 = 32'h00318233;  // add  x4,x3,x3
    localparam logic [31:0] I_ADD00 = 32'h00000233;  // add  x4,x0,x0

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1, wb_we = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0, wb_data = '0;
    logic [4:0]  wb_rd = '0;

    logic        o_ready [ND];
    logic        o_valid [ND];
    logic        o_hz    [ND];
    logic [13:0] o_ctrl  [ND];
    logic [31:0] o_pc    [ND];
    logic [31:0] o_rd1   [ND];
    logic [31:0] o_rd2   [ND];
    logic [31:0] o_imm   [ND];
    logic [31:0] o_instr [ND];
    logic [4:0]  o_rs1   [ND];
    logic [4:0]  o_rs2   [ND];
    logic [4:0]  o_rdx   [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        decode_stage_sb #(
            .XLEN      (32),
            .NREG      (32),
            .LOAD_LAT  ((g == 1) ? 2 : 0),
            .WB_BYPASS ((g == 2) ? 0 : 1)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (o_ready[g]),
            .in_pc      (in_pc),
            .in_instr   (in_instr),
            .wb_we      (wb_we),
            .wb_rd      (wb_rd),
            .wb_data    (wb_data),
            .flush      (flush),
            .ex_ready   (ex_ready),
            .out_valid  (o_valid[g]),
            .out_ctrl   (o_ctrl[g]),
            .out_pc     (o_pc[g]),
            .out_rdata1 (o_rd1[g]),
            .out_rdata2 (o_rd2[g]),
            .out_imm    (o_imm[g]),
            .out_rs1    (o_rs1[g]),
            .out_rs2    (o_rs2[g]),
            .out_rd     (o_rdx[g]),
            .out_instr  (o_instr[g]),
            .hz_stall   (o_hz[g])
        );
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [13:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0;
        wb_rd = '0; wb_data = '0; in_instr = '0; in_pc = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // present ins until DUT d takes it; returns cycles refused and cycles with hz_stall high
    task automatic issue(input int d, input logic [31:0] ins, output int stalls, output int hzc);
        in_valid = 1'b1; in_instr = ins; in_pc = in_pc + 32'd4;
        stalls = 0; hzc = 0;
        forever begin
            @(negedge clk);
            if (o_hz[d]) hzc++;
            if (o_ready[d] || stalls > 20) break;
            stalls++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int s, h;

        vt[0]  = '{32'h00228333, 14'h1000, 32'h00000002, 5'd5,  5'd2,  5'd6};   // add
        vt[1]  = '{32'h402083B3, 14'h1001, 32'h00000402, 5'd1,  5'd2,  5'd7};   // sub
        vt[2]  = '{32'hFFF00093, 14'h1100, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1};   // addi -1
        vt[3]  = '{32'h0000A283, 14'h1940, 32'h00000000, 5'd1,  5'd0,  5'd5};   // lw
        vt[4]  = '{32'hFE20AE23, 14'h0500, 32'hFFFFFFFC, 5'd1,  5'd2,  5'd28};  // sw -4
        vt[5]  = '{32'hFE208CE3, 14'h0021, 32'hFFFFFFF8, 5'd1,  5'd2,  5'd25};  // beq -8
        vt[6]  = '{32'h123452B7, 14'h110A, 32'h12345000, 5'd8,  5'd3,  5'd5};   // lui
        vt[7]  = '{32'h008002EF, 14'h1290, 32'h00000008, 5'd0,  5'd8,  5'd5};   // jal +8
        vt[8]  = '{32'h004100E7, 14'h1190, 32'h00000004, 5'd2,  5'd4,  5'd1};   // jalr
        vt[9]  = '{32'hFFFFF197, 14'h1200, 32'hFFFFF000, 5'd31, 5'd31, 5'd3};   // auipc
        vt[10] = '{32'hFFFFFFFF, 14'h0000, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd31};  // unknown
        vt[11] = '{32'h40325213, 14'h1107, 32'h00000403, 5'd4,  5'd3,  5'd4};   // srai

        // reset state
        #3 rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset d%0d out_valid", d), o_valid[d], 1'b0);
            check($sformatf("reset d%0d out_ctrl", d), o_ctrl[d], 14'h0);
            check($sformatf("reset d%0d out_imm", d), o_imm[d], 32'h0);
        end
        do_reset();

        // decode table, one per cycle on d0
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'h100 + 32'(4 * i);
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), o_ready[0], 1'b1);
            @(posedge clk); #1;
            check($sformatf("vec%0d out_valid", i), o_valid[0], 1'b1);
            check($sformatf("vec%0d ctrl", i), o_ctrl[0], vt[i].ctrl);
            check($sformatf("vec%0d imm", i), o_imm[0], vt[i].imm);
            check($sformatf("vec%0d pc", i), o_pc[0], 32'h100 + 32'(4 * i));
            check($sformatf("vec%0d regs", i), {o_rs1[0], o_rs2[0], o_rdx[0]}, {vt[i].rs1, vt[i].rs2, vt[i].rd});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle out_valid", o_valid[0], 1'b0);

        // load-use, LOAD_LAT=0: one bubble
        do_reset();
        issue(0, I_LW, s, h);
        issue(0, I_ADD, s, h);
        check("lat0 stalls", s, 1);
        check("lat0 hz cycles", h, 1);
        check("lat0 add rs1", o_rs1[0], 5'd5);
        check("lat0 add valid", o_valid[0], 1'b1);

        // LOAD_LAT=2: three bubbles; independent op none
        do_reset();
        issue(1, I_LW, s, h);
        issue(1, I_ADD, s, h);
        check("lat2 stalls", s, 3);
        check("lat2 hz cycles", h, 3);
        check("lat2 add rs1", o_rs1[1], 5'd5);
        do_reset();
        issue(1, I_LW, s, h);
        issue(1, I_ADDI, s, h);
        check("lat2 indep stalls", s, 0);

        // LUI/JAL ignore rs fields behind a load of x5
        do_reset();
        issue(1, I_LW, s, h);
        issue(1, I_LUI, s, h);
        check("lui stalls", s, 0);
        check("lui imm", o_imm[1], 32'h12345000);
        issue(1, I_JAL, s, h);
        check("jal stalls", s, 0);
        check("jal imm", o_imm[1], 32'h00000008);

        // EX backpressure holds ID/EX
        do_reset();
        issue(0, I_NEG, s, h);
        ex_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d in_ready", k), o_ready[0], 1'b0);
            check($sformatf("bp%0d out_instr", k), o_instr[0], I_NEG);
            check($sformatf("bp%0d out_valid", k), o_valid[0], 1'b1);
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp release in_ready", o_ready[0], 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp release out_instr", o_instr[0], I_ADDI);

        // flush kills a live ID/EX entry
        do_reset();
        issue(0, I_NEG, s, h);
        flush = 1'b1; in_valid = 1'b1; in_instr = I_ADDI;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush live out_valid", o_valid[0], 1'b0);

        // flush during a LOAD_LAT=2 stall; older load keeps counting
        do_reset();
        issue(1, I_LW, s, h);
        in_valid = 1'b1; in_instr = I_ADD;
        @(negedge clk);
        check("fl stall hz/ready", {o_hz[1], o_ready[1]}, 2'b10);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("fl in_ready", o_ready[1], 1'b1);
        @(posedge clk); #1 flush = 1'b0;
        check("fl out_valid", o_valid[1], 1'b0);
        issue(1, I_ADD, s, h);
        check("fl refetch stalls", s, 1);
        check("fl refetch rs1", o_rs1[1], 5'd5);

        // async reset in the middle of a stall
        do_reset();
        issue(1, I_LW, s, h);
        in_valid = 1'b1; in_instr = I_ADD;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("mid-reset out_valid", o_valid[1], 1'b0);
        check("mid-reset hz_stall", o_hz[1], 1'b0);
        rst = 1'b1;
        issue(1, I_ADD, s, h);
        check("post-reset stalls", s, 0);
        check("post-reset out_rd", {o_valid[1], o_rdx[1]}, {1'b1, 5'd6});

        // writeback bypass vs. old value, and x0
        do_reset();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h11111111;
        @(posedge clk); #1;
        wb_data = 32'hDEADBEEF; in_valid = 1'b1; in_instr = I_ADD33;
        @(posedge clk); #1;
        wb_we = 1'b0;
        check("byp rdata1", o_rd1[0], 32'hDEADBEEF);
        check("byp rdata2", o_rd2[0], 32'hDEADBEEF);
        check("nobyp rdata1", o_rd1[2], 32'h11111111);
        check("nobyp rdata2", o_rd2[2], 32'h11111111);
        @(posedge clk); #1;
        check("nobyp later rdata1", o_rd1[2], 32'hDEADBEEF);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hCAFEF00D; in_instr = I_ADD00;
        @(posedge clk); #1;
        wb_we = 1'b0;
        check("x0 bypass rdata", {o_rd1[0], o_rd2[0]}, 64'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("x0 after write", o_rd1[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
